// File: rtl/multdiv_ctrl.sv
// Sequencer for the multi-cycle multiplier/divider: detects R-type mul/div, stalls the pipeline,
// starts multdiv, waits for its result and issues one writeback. Optional WAIT abort: MULTDIV_TIMEOUT_EN.
module multdiv_ctrl #(
    parameter int RSTATUS_REG = 30,
    parameter int MUL_STATUS  = 4,
    parameter int DIV_STATUS  = 5,
    parameter int TIMEOUT     = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ins,
    input  logic        ins_valid,
    input  logic [31:0] data_rs,
    input  logic [31:0] data_rt,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, WB = 2'd3} state_t;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    state_t      state, state_next;
    logic        md_ins;
    logic        timeout_hit;
    logic [4:0]  rd_q;
    logic        is_div_q;
    logic [31:0] res_q;
    logic        exc_q;
    logic        unused_ok;

    assign md_ins = ins_valid && (ins[31:27] == 5'b00000) &&
                    ((ins[6:2] == ALU_MUL) || (ins[6:2] == ALU_DIV));

    assign unused_ok = ^{ins[21:7], ins[1:0], TIMEOUT[0]};

`ifdef MULTDIV_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == START) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands and destination are captured at accept; ins is ignored for the rest of the operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            md_opA   <= '0;
            md_opB   <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
        end else begin
            if (state == IDLE && md_ins) begin
                md_opA   <= data_rs;
                md_opB   <= data_rt;
                rd_q     <= ins[26:22];
                is_div_q <= (ins[6:2] == ALU_DIV);
            end
            if (state == WAIT) begin
                if (md_ready) begin
                    res_q <= md_result;
                    exc_q <= md_exception;
                end else if (timeout_hit) begin
                    exc_q <= 1'b1;
                end
            end
        end
    end

    // Handshake: md_ctrl_* is a one-cycle start strobe; md_ready is a one-cycle result-valid
    // strobe, honoured only in WAIT, with md_exception/md_result qualified by it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (md_ins) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (md_ready || timeout_hit) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        stall        = 1'b0;
        wb_en        = 1'b0;
        wb_reg       = '0;
        wb_data      = '0;
        case (state)
            IDLE: stall = md_ins;
            START: begin
                md_ctrl_mult = !is_div_q;
                md_ctrl_div  = is_div_q;
                stall        = 1'b1;
            end
            WAIT: stall = 1'b1;
            WB: begin
                if (exc_q) begin
                    wb_reg  = RSTATUS_REG[4:0];
                    wb_data = is_div_q ? 32'(DIV_STATUS) : 32'(MUL_STATUS);
                end else begin
                    wb_reg  = rd_q;
                    wb_data = res_q;
                end
                // $r0 is hard-wired zero, so a writeback aimed there is dropped
                wb_en = (wb_reg != 5'd0);
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: hand-computed writebacks, stall lengths, pulse counts,
// reset abort and (with MULTDIV_TIMEOUT_EN) the WAIT timeout.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic [31:0] data_rs = '0;
    logic [31:0] data_rt = '0;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_ready = 1'b0;
    logic        md_ctrl_mult, md_ctrl_div, stall, wb_en, busy;
    logic [31:0] md_opA, md_opB, wb_data;
    logic [4:0]  wb_reg;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    multdiv_ctrl #(.RSTATUS_REG(30), .MUL_STATUS(4), .DIV_STATUS(5), .TIMEOUT(8)) dut (
        .clock(clock), .reset_n(reset_n), .ins(ins), .ins_valid(ins_valid),
        .data_rs(data_rs), .data_rt(data_rt), .md_result(md_result),
        .md_exception(md_exception), .md_ready(md_ready),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_opA(md_opA), .md_opB(md_opB), .stall(stall), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] alu);
        return {5'b00000, rd, 15'b0, alu, 2'b00};
    endfunction

    // Cycle 0 = detect; ready arrives in WAIT cycle dly (cycle dly+1); WB is cycle dly+2.
    // The instruction stays valid throughout to show it is ignored outside IDLE.
    task automatic run_op(input string tag, input logic [31:0] i, input logic [31:0] a,
                          input logic [31:0] b, input int dly, input logic give_rdy,
                          input logic [31:0] res, input logic exc, input logic [4:0] e_reg,
                          input logic [31:0] e_data, input logic e_en);
        int stalls = 0;
        int mults = 0;
        int divs = 0;
        logic dv = i[2];
        @(negedge clock);
        ins = i; ins_valid = 1'b1; data_rs = a; data_rt = b; md_ready = 1'b0;
        #1;
        chk({tag, "_det_stall"}, 32'(stall), 32'd1);
        chk({tag, "_det_busy"}, 32'(busy), 32'd0);
        stalls += int'(stall); mults += int'(md_ctrl_mult); divs += int'(md_ctrl_div);
        for (int c = 1; c <= dly + 2; c++) begin
            @(negedge clock);
            data_rs = $urandom; data_rt = $urandom;
            md_ready     = give_rdy && (c == dly + 1);
            md_result    = (c == dly + 1) ? res : $urandom;
            md_exception = (c == dly + 1) ? exc : 1'($urandom_range(0, 1));
            #1;
            stalls += int'(stall); mults += int'(md_ctrl_mult); divs += int'(md_ctrl_div);
            if (c == 1) begin
                chk({tag, "_opA"}, md_opA, a);
                chk({tag, "_opB"}, md_opB, b);
                chk({tag, "_busy"}, 32'(busy), 32'd1);
            end
            if (c <= dly + 1) begin
                chk({tag, "_early_wb_en"}, 32'(wb_en), 32'd0);
            end else begin
                chk({tag, "_wb_en"}, 32'(wb_en), 32'(e_en));
                chk({tag, "_wb_reg"}, 32'(wb_reg), 32'(e_reg));
                chk({tag, "_wb_data"}, wb_data, e_data);
                chk({tag, "_wb_stall"}, 32'(stall), 32'd0);
            end
        end
        md_ready = 1'b0;
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(dly + 2));
        chk({tag, "_mult_pulses"}, 32'(mults), dv ? 32'd0 : 32'd1);
        chk({tag, "_div_pulses"}, 32'(divs), dv ? 32'd1 : 32'd0);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clock);
        ins_valid = 1'b0; md_ready = 1'b0;
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_wb_en"}, 32'(wb_en), 32'd0);
    endtask

    task automatic non_md(input string tag, input logic [31:0] i, input logic v);
        @(negedge clock);
        ins = i; ins_valid = v;
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        @(negedge clock);
        ins_valid = 1'b0;
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pulse"}, 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb", {wb_en, wb_reg, wb_data[25:0]}, 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul_rd3", 32'h00C3_0018, 32'd6, 32'd7, 4, 1'b1, 32'd42, 1'b0, 5'd3, 32'd42, 1'b1);
        run_op("div_by0", mk(5'd5, 5'b00111), 32'd100, 32'd0, 2, 1'b1, 32'hDEAD_BEEF, 1'b1,
               5'd30, 32'd5, 1'b1);
        run_op("mul_rd0", mk(5'd0, 5'b00110), 32'd9, 32'd9, 1, 1'b1, 32'd81, 1'b0, 5'd0, 32'd81, 1'b0);
        idle_chk("after_rd0");

        non_md("add", mk(5'd3, 5'b00000), 1'b1);
        non_md("mul_invalid", mk(5'd3, 5'b00110), 1'b0);

        run_op("b2b_mul", mk(5'd7, 5'b00110), 32'd3, 32'd4, 2, 1'b1, 32'd12, 1'b0, 5'd7, 32'd12, 1'b1);
        run_op("b2b_div", mk(5'd8, 5'b00111), 32'd20, 32'd4, 3, 1'b1, 32'd5, 1'b0, 5'd8, 32'd5, 1'b1);
        idle_chk("after_b2b");
        run_op("mul_ovf", mk(5'd9, 5'b00110), 32'h8000_0000, 32'd2, 1, 1'b1, 32'd0, 1'b1,
               5'd30, 32'd4, 1'b1);

        // Reset in WAIT abandons the op; a late ready must not produce a writeback.
        @(negedge clock);
        ins = mk(5'd6, 5'b00110); ins_valid = 1'b1; data_rs = 32'd11; data_rt = 32'd13;
        @(negedge clock);
        ins_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rstw_state", 32'(fsm_state), 32'd0);
        chk("rstw_ctl", 32'({md_ctrl_mult, md_ctrl_div, stall, busy, wb_en}), 32'd0);
        chk("rstw_wb", {27'd0, wb_reg} | wb_data, 32'd0);
        chk("rstw_ops", md_opA | md_opB, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        md_ready = 1'b1; md_result = 32'd143; md_exception = 1'b0;
        #1;
        chk("rstw_rdy_wb_en", 32'(wb_en), 32'd0);
        @(negedge clock);
        md_ready = 1'b0;
        #1;
        chk("rstw_rdy_wb_en2", 32'(wb_en), 32'd0);
        chk("rstw_rdy_busy", 32'(busy), 32'd0);

`ifdef MULTDIV_TIMEOUT_EN
        run_op("timeout", mk(5'd4, 5'b00110), 32'd1, 32'd2, 8, 1'b0, 32'd0, 1'b0,
               5'd30, 32'd4, 1'b1);
        idle_chk("after_timeout");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=%0d exp=%0d", 1, 0);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
